syncgen_cfg: RTL and testbench

- Parametrised, run-time reconfigurable video timing generator; successor to the fixed 640x480 sync generator.
- Runs directly on the pixel clock supplied by the top level. It contains no clock generation.
- Produces HS/VS with selectable polarity, a data-enable output, active-area coordinates and line/frame start pulses.
- A timing set written mid-frame is shadowed and applied only at the frame boundary, so raster output never tears.

---
 rtl/syncgen_cfg.sv | 126 ++++++++++++
 tb/tb_syncgen_cfg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/syncgen_cfg.sv
// Run-time reconfigurable raster timing generator on the pixel clock.
// Timing writes are shadowed and applied at the frame boundary.
module syncgen_cfg #(
  parameter int unsigned CW       = 11,
  parameter int unsigned DEF_HACT = 640,
  parameter int unsigned DEF_HFP  = 16,
  parameter int unsigned DEF_HSW  = 96,
  parameter int unsigned DEF_HBP  = 48,
  parameter int unsigned DEF_VACT = 480,
  parameter int unsigned DEF_VFP  = 10,
  parameter int unsigned DEF_VSW  = 2,
  parameter int unsigned DEF_VBP  = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CFG_WE,
  input  logic [CW-1:0] CFG_HACT,
  input  logic [CW-1:0] CFG_HFP,
  input  logic [CW-1:0] CFG_HSW,
  input  logic [CW-1:0] CFG_HBP,
  input  logic [CW-1:0] CFG_VACT,
  input  logic [CW-1:0] CFG_VFP,
  input  logic [CW-1:0] CFG_VSW,
  input  logic [CW-1:0] CFG_VBP,
  output logic          CFG_PEND,
  output logic          CFG_ERR,
  output logic [CW-1:0] HCNT,
  output logic [CW-1:0] VCNT,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic          LINE_START,
  output logic          FRAME_START
);

  typedef struct packed {
    logic [CW-1:0] act;
    logic [CW-1:0] fp;
    logic [CW-1:0] sw;
    logic [CW-1:0] bp;
  } tim_t;

  localparam tim_t DEF_H = '{act: CW'(DEF_HACT), fp: CW'(DEF_HFP),
                             sw: CW'(DEF_HSW), bp: CW'(DEF_HBP)};
  localparam tim_t DEF_V = '{act: CW'(DEF_VACT), fp: CW'(DEF_VFP),
                             sw: CW'(DEF_VSW), bp: CW'(DEF_VBP)};
  localparam logic [CW+1:0] TOT_MAX = {2'b01, {CW{1'b0}}};

  function automatic logic [CW+1:0] total(input tim_t t);
    return {2'b00, t.act} + {2'b00, t.fp} + {2'b00, t.sw} + {2'b00, t.bp};
  endfunction

  tim_t live_h, live_v, shd_h, shd_v, new_h, new_v;
  logic [CW+1:0] htot, vtot, hc, vc, hs_beg, vs_beg;
  logic          h_last, v_last, hs_on, vs_on, cfg_ok;

  always_comb begin
    new_h  = '{act: CFG_HACT, fp: CFG_HFP, sw: CFG_HSW, bp: CFG_HBP};
    new_v  = '{act: CFG_VACT, fp: CFG_VFP, sw: CFG_VSW, bp: CFG_VBP};
    cfg_ok = (|CFG_HACT) && (|CFG_HSW) && (|CFG_VACT) && (|CFG_VSW) &&
             (total(new_h) <= TOT_MAX) && (total(new_v) <= TOT_MAX);
    htot   = total(live_h);
    vtot   = total(live_v);
    hc     = {2'b00, HCNT};
    vc     = {2'b00, VCNT};
    h_last = (hc == htot - 1'b1);
    v_last = (vc == vtot - 1'b1);
    hs_beg = {2'b00, live_h.act} + {2'b00, live_h.fp};
    vs_beg = {2'b00, live_v.act} + {2'b00, live_v.fp};
    hs_on  = (hc >= hs_beg) && (hc < hs_beg + {2'b00, live_h.sw});
    vs_on  = (vc >= vs_beg) && (vc < vs_beg + {2'b00, live_v.sw});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      HCNT        <= '0;
      VCNT        <= '0;
      live_h      <= DEF_H;
      live_v      <= DEF_V;
      shd_h       <= DEF_H;
      shd_v       <= DEF_V;
      CFG_PEND    <= 1'b0;
      CFG_ERR     <= 1'b0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_DE      <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      if (h_last) begin
        HCNT <= '0;
        VCNT <= v_last ? '0 : VCNT + CW'(1);
      end else begin
        HCNT <= HCNT + CW'(1);
      end

      // Apply reads the old shadow; a same-cycle write then re-arms CFG_PEND.
      if (h_last && v_last && CFG_PEND) begin
        live_h   <= shd_h;
        live_v   <= shd_v;
        CFG_PEND <= 1'b0;
      end
      if (CFG_WE) begin
        if (cfg_ok) begin
          shd_h    <= new_h;
          shd_v    <= new_v;
          CFG_PEND <= 1'b1;
          CFG_ERR  <= 1'b0;
        end else begin
          CFG_ERR  <= 1'b1;
        end
      end

      VGA_DE      <= (hc < {2'b00, live_h.act}) && (vc < {2'b00, live_v.act});
      VGA_HS      <= hs_on ? HS_POL : ~HS_POL;
      // Loaded on the same edge that asserts HS so both sync edges line up.
      if (hc == hs_beg)
        VGA_VS    <= vs_on ? VS_POL : ~VS_POL;
      LINE_START  <= (HCNT == '0);
      FRAME_START <= (HCNT == '0) && (VCNT == '0);
    end
  end

endmodule

// File: tb/tb_syncgen_cfg.sv
// Directed bench: one default 640x480 instance and one small-timing,
// positive-polarity instance used for the reconfiguration scenarios.
module tb_syncgen_cfg;
  logic        clk = 1'b0;
  logic        rst_a, rst_b, we_a, we_b;
  logic [10:0] c_hact, c_hfp, c_hsw, c_hbp, c_vact, c_vfp, c_vsw, c_vbp;

  logic        a_pend, a_err, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [10:0] a_hcnt, a_vcnt;
  logic        b_pend, b_err, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [10:0] b_hcnt, b_vcnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  syncgen_cfg u_def (
    .CLK(clk), .RST(rst_a), .CFG_WE(we_a),
    .CFG_HACT(c_hact), .CFG_HFP(c_hfp), .CFG_HSW(c_hsw), .CFG_HBP(c_hbp),
    .CFG_VACT(c_vact), .CFG_VFP(c_vfp), .CFG_VSW(c_vsw), .CFG_VBP(c_vbp),
    .CFG_PEND(a_pend), .CFG_ERR(a_err), .HCNT(a_hcnt), .VCNT(a_vcnt),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_DE(a_de),
    .LINE_START(a_ls), .FRAME_START(a_fs)
  );

  syncgen_cfg #(
    .DEF_HACT(10), .DEF_HFP(3), .DEF_HSW(2), .DEF_HBP(5),
    .DEF_VACT(6),  .DEF_VFP(2), .DEF_VSW(2), .DEF_VBP(3),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_cfg (
    .CLK(clk), .RST(rst_b), .CFG_WE(we_b),
    .CFG_HACT(c_hact), .CFG_HFP(c_hfp), .CFG_HSW(c_hsw), .CFG_HBP(c_hbp),
    .CFG_VACT(c_vact), .CFG_VFP(c_vfp), .CFG_VSW(c_vsw), .CFG_VBP(c_vbp),
    .CFG_PEND(b_pend), .CFG_ERR(b_err), .HCNT(b_hcnt), .VCNT(b_vcnt),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_DE(b_de),
    .LINE_START(b_ls), .FRAME_START(b_fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input bit to_a, input int ha, hf, hs, hb, va, vf, vs, vb);
    c_hact = 11'(ha); c_hfp = 11'(hf); c_hsw = 11'(hs); c_hbp = 11'(hb);
    c_vact = 11'(va); c_vfp = 11'(vf); c_vsw = 11'(vs); c_vbp = 11'(vb);
    if (to_a) we_a = 1'b1; else we_b = 1'b1;
    tick();
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic wait_fs(input string tag, input int lim);
    int n = 0;
    while (!b_fs && n < lim) begin
      tick();
      n++;
    end
    check({tag, "_fs_wait"}, b_fs, 1);
  endtask

  // Entered on a FRAME_START sample; ends on the next one.
  task automatic measure_frame(input string tag, input int e_per, e_de, e_hs, e_vs, e_lo, e_hi);
    int per = 0, de = 0, hs = 0, vs = 0, align = 0, hserr = 0;
    logic [10:0] ph = '0;
    logic pv = b_vs, phs = b_hs;
    do begin
      if (b_de) de++;
      if (b_hs) hs++;
      if (b_vs) vs++;
      if (b_hs != (int'(ph) >= e_lo && int'(ph) <= e_hi)) hserr++;
      if (per > 0 && b_vs != pv && !(b_hs && !phs)) align++;
      pv = b_vs; phs = b_hs; ph = b_hcnt; per++;
      tick();
    end while (!b_fs && per < 5000);
    check({tag, "_period"}, per, e_per);
    check({tag, "_de"}, de, e_de);
    check({tag, "_hs"}, hs, e_hs);
    check({tag, "_vs"}, vs, e_vs);
    check({tag, "_hs_pos"}, hserr, 0);
    check({tag, "_vs_align"}, align, 0);
  endtask

  initial begin
    int hs_low, hs_err, de_cnt, de_err, vs_low, ls_cnt, wrap_i, wrap_v, n, t0;
    logic [10:0] ph;
    rst_a = 1'b1; rst_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    c_hact = '0; c_hfp = '0; c_hsw = '0; c_hbp = '0;
    c_vact = '0; c_vfp = '0; c_vsw = '0; c_vbp = '0;
    repeat (3) tick();

    check("rst_hcnt", a_hcnt, 0);
    check("rst_vcnt", a_vcnt, 0);
    check("rst_hs", a_hs, 1);
    check("rst_vs", a_vs, 1);
    check("rst_de", a_de, 0);
    check("rst_ls", a_ls, 0);
    check("rst_fs", a_fs, 0);
    check("rst_pend", a_pend, 0);
    check("rst_err", a_err, 0);
    check("pol_rst_hs", b_hs, 0);
    check("pol_rst_vs", b_vs, 0);

    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    check("def_first_fs", a_fs, 1);
    check("def_first_hcnt", a_hcnt, 1);

    hs_low = 0; hs_err = 0; de_cnt = 0; de_err = 0; vs_low = 0; ls_cnt = 0;
    wrap_i = -1; wrap_v = -1; ph = '0;
    for (int i = 0; i < 1600; i++) begin
      if (!a_hs) hs_low++;
      if ((!a_hs) != (ph >= 656 && ph <= 751)) hs_err++;
      if (a_de) de_cnt++;
      if (a_de != (ph < 640)) de_err++;
      if (!a_vs) vs_low++;
      if (a_ls) ls_cnt++;
      if (a_hcnt == 0 && wrap_i < 0) begin
        wrap_i = i;
        wrap_v = a_vcnt;
      end
      ph = a_hcnt;
      tick();
    end
    check("def_hs_low", hs_low, 192);
    check("def_hs_pos", hs_err, 0);
    check("def_de_cnt", de_cnt, 1280);
    check("def_de_pos", de_err, 0);
    check("def_vs_idle", vs_low, 0);
    check("def_ls_cnt", ls_cnt, 2);
    check("def_wrap_at", wrap_i, 799);
    check("def_wrap_vcnt", wrap_v, 1);

    wr(1'b1, 8, 2, 2, 2, 4, 1, 1, 1);
    check("def_pend_set", a_pend, 1);
    repeat (37) tick();
    rst_a = 1'b1;
    tick();
    check("mrst_hcnt", a_hcnt, 0);
    check("mrst_vcnt", a_vcnt, 0);
    check("mrst_pend", a_pend, 0);
    check("mrst_fs_low", a_fs, 0);
    rst_a = 1'b0;
    tick();
    check("mrst_fs", a_fs, 1);
    check("mrst_hcnt1", a_hcnt, 1);
    n = 0;
    while (a_hcnt != 0 && n < 2000) begin
      tick();
      n++;
    end
    check("mrst_line_len", n, 799);

    wait_fs("b0", 600);
    measure_frame("bdef", 260, 60, 26, 40, 13, 14);
    t0 = cyc;
    wr(1'b0, 0, 2, 2, 2, 4, 1, 1, 1);
    check("rej_hact_err", b_err, 1);
    check("rej_hact_pend", b_pend, 0);
    wr(1'b0, 2000, 20, 20, 20, 4, 1, 1, 1);
    check("rej_ovf_err", b_err, 1);
    check("rej_ovf_pend", b_pend, 0);
    wr(1'b0, 8, 2, 2, 2, 4, 1, 1, 1);
    check("ok_err_clr", b_err, 0);
    check("ok_pend", b_pend, 1);
    repeat (100) tick();
    check("ok_pend_hold", b_pend, 1);
    wait_fs("b1", 400);
    check("old_frame_len", cyc - t0, 260);
    check("apply_pend_clr", b_pend, 0);
    measure_frame("small", 98, 32, 14, 14, 10, 11);

    wr(1'b0, 6, 1, 1, 1, 3, 1, 1, 1);
    check("wa_pend", b_pend, 1);
    n = 0;
    while (!(b_hcnt == 13 && b_vcnt == 6) && n < 300) begin
      tick();
      n++;
    end
    check("apply_cycle_h", b_hcnt, 13);
    wr(1'b0, 5, 1, 2, 2, 2, 1, 1, 1);
    check("wb_hcnt0", b_hcnt, 0);
    check("wb_vcnt0", b_vcnt, 0);
    check("wb_pend", b_pend, 1);
    check("wb_err", b_err, 0);
    wait_fs("b2", 10);
    measure_frame("wa", 54, 18, 6, 9, 7, 7);
    check("wb_applied_pend", b_pend, 0);
    measure_frame("wb", 50, 10, 10, 10, 6, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
